// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and divider FSM state type
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int CNT_WIDTH = $clog2(ALU_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_16_if.sv
// rtl/div_16_if.sv - request/result bundle between the execute stage and the divider
interface div_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_16.sv
// rtl/cla_16.sv - generate/propagate adder used as the divider's trial subtractor
module cla_16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic [WIDTH:0] c;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[WIDTH-1:0];
        cout = c[WIDTH];
    end
endmodule

// File: rtl/div_16.sv
// rtl/div_16.sv - sequential restoring divider, fixed WIDTH+1 latency; DIV_SIGNED_EN adds signed mode
module div_16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic    clk,
    input  logic    rst,
    div_16_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r, q, dvsr, dvnd_raw;
    logic             zero_div;
    logic             busy_r, done_r, dbz_r;
    logic [WIDTH-1:0] quot_r, rem_r;

    logic [WIDTH-1:0] a_mag, b_mag, q_res, r_res;
    logic [WIDTH-1:0] trial;
    logic             cout, no_borrow;
    logic [WIDTH:0]   shifted;

    // q doubles as the dividend shift register: its MSB feeds R, quotient bits enter at the LSB
    assign shifted = {r, q[WIDTH-1]};

    cla_16 #(.WIDTH(WIDTH)) u_trial (
        .a    (shifted[WIDTH-1:0]),
        .b    (~dvsr),
        .cin  (1'b1),
        .sum  (trial),
        .cout (cout)
    );

    assign no_borrow = shifted[WIDTH] | cout;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, neg_r;
    assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
    assign q_res = neg_q ? -q : q;
    assign r_res = neg_r ? -r : r;
`else
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
    assign q_res = q;
    assign r_res = r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            dvsr     <= '0;
            dvnd_raw <= '0;
            zero_div <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            quot_r   <= '0;
            rem_r    <= '0;
`ifdef DIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q        <= a_mag;
                        dvsr     <= b_mag;
                        dvnd_raw <= bus.dividend;
                        r        <= '0;
                        cnt      <= CW'(WIDTH - 1);
                        zero_div <= (bus.divisor == '0);
                        busy_r   <= 1'b1;
                        state    <= CALC;
`ifdef DIV_SIGNED_EN
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
`endif
                    end
                end
                CALC: begin
                    if (!zero_div) begin
                        q <= {q[WIDTH-2:0], no_borrow};
                        r <= no_borrow ? trial : shifted[WIDTH-1:0];
                    end
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                    if (zero_div) begin
                        quot_r <= '1;
                        rem_r  <= dvnd_raw;
                        dbz_r  <= 1'b1;
                    end else begin
                        quot_r <= q_res;
                        rem_r  <= r_res;
                        dbz_r  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_16.sv
// tb/tb_div_16.sv - scoreboard bench for div_16 with randomized operands
module tb_div_16;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int LAT = 17;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t last_e;

    div_16_if #(.WIDTH(16)) bus ();

    div_16 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        int   sa, sd;
        e.cyc = 0;
        if (b == 16'd0) begin
            e.q = 16'hFFFF;
            e.r = a;
            e.z = 1'b1;
        end else if (s && SIGNED_EN) begin
            sa  = $signed(a);
            sd  = $signed(b);
            e.q = 16'(sa / sd);
            e.r = 16'(sa % sd);
            e.z = 1'b0;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: got q=%h r=%h dbz=%b at cycle %0d, no request pending",
                         bus.quotient, bus.remainder, bus.div_by_zero, cyc);
            end else begin
                mon_e  = exp_q.pop_front();
                last_e = mon_e;
                if (bus.quotient !== mon_e.q || bus.remainder !== mon_e.r ||
                    bus.div_by_zero !== mon_e.z || cyc != mon_e.cyc || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL result: got q=%h r=%h dbz=%b busy=%b cycle=%0d, expected q=%h r=%h dbz=%b busy=0 cycle=%0d",
                             bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, cyc,
                             mon_e.q, mon_e.r, mon_e.z, mon_e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input bit track);
        exp_t e;
        bus.start     = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 16'($urandom);
        if (track) begin
            e     = model(a, b, s);
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        while (!bus.done && n < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end else if (!busy_ok) begin
            failures++;
            $display("FAIL busy_window: busy dropped before done, required high until done");
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
            bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b q=%h r=%h dbz=%b, required all 0",
                     name, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic [15:0] a, b;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = 16'd0;
        bus.divisor   = 16'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        issue(16'd1000, 16'd7, 1'b0, 1'b1);
        wait_done();
        issue(16'h1234, 16'd0, 1'b0, 1'b1);
        wait_done();
        issue(16'hFFF9, 16'd2, 1'b1, 1'b1);
        wait_done();
        issue(16'h8000, 16'hFFFF, 1'b1, 1'b1);
        wait_done();
        issue(16'h1234, 16'd0, 1'b1, 1'b1);
        wait_done();

        repeat (4) @(negedge clk);
        checks++;
        if (bus.quotient !== last_e.q || bus.remainder !== last_e.r || bus.div_by_zero !== last_e.z) begin
            failures++;
            $display("FAIL result_hold: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                     bus.quotient, bus.remainder, bus.div_by_zero, last_e.q, last_e.r, last_e.z);
        end

        issue(16'd100, 16'd10, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd999;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        issue(16'd40000, 16'd3, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset_mid_calc");
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL no_done_after_reset: saw %0d done pulses, required 0", ndone);
        end
        issue(16'd65535, 16'd255, 1'b0, 1'b1);
        wait_done();

        issue(16'd50, 16'd3, 1'b0, 1'b1);
        wait_done();
        issue(16'd9, 16'd4, 1'b0, 1'b1);
        wait_done();

        for (int i = 0; i < 150; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b, 1'($urandom_range(0, 1)), 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drained: %0d results outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
